mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the core's read/write channel interfaces. It accepts requests from up to NUM_CONSUMERS LSU or fetcher channels, arbitrates them onto NUM_CHANNELS external memory ports, and returns data and ready to each requester. It sits between the cores and the DCACHE/PCACHE, answering the valid/address/data initiators driven by the LSUs and fetchers.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- NUM_CONSUMERS, 8, requester channels (LSUs/fetchers)
- NUM_CHANNELS, 4, concurrent external memory ports
- WRITE_ENABLE, 1, 0 = read-only instance (program memory)

- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- consumer_read_valid  in  [NUM_CONSUMERS]  read request held until ready
- consumer_read_address  in  [NUM_CONSUMERS][ADDR_BITS]  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid
- consumer_read_data  out  [NUM_CONSUMERS][DATA_BITS]  returned data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request
- consumer_write_address  in  [NUM_CONSUMERS][ADDR_BITS]  write address
- consumer_write_data  in  [NUM_CONSUMERS][DATA_BITS]  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write done
- mem_read_valid  out  [NUM_CHANNELS]  memory read request
- mem_read_address  out  [NUM_CHANNELS][ADDR_BITS]
- mem_read_ready  in  [NUM_CHANNELS]  memory read complete
- mem_read_data  in  [NUM_CHANNELS][DATA_BITS]
- mem_write_valid  out  [NUM_CHANNELS]  memory write request
- mem_write_address  out  [NUM_CHANNELS][ADDR_BITS]
- mem_write_data  out  [NUM_CHANNELS][DATA_BITS]
- mem_write_ready  in  [NUM_CHANNELS]  memory write complete

## Operation
- Per-channel FSM: IDLE, READ_WAITING, WRITE_WAITING, READ_RELAYING, WRITE_RELAYING.
- IDLE: claim a consumer. Channels are evaluated in ascending index. Each idle channel takes the lowest-index consumer that has read or write valid and is unclaimed, counting claims made by lower channels in the same cycle.
  - Read has priority over write on the same consumer.
  - The claim latches the address, the data, and the consumer index.
  - Next state is READ_WAITING or WRITE_WAITING.
- *_WAITING: mem_*_valid is high with the latched address/data. When mem_*_ready is sampled high:
  - Drop mem_*_valid.
  - For reads, register mem_read_data into consumer_read_data[idx].
  - Raise consumer_*_ready[idx] and go to *_RELAYING.
- *_RELAYING: hold ready and data until consumer_*_valid[idx] is sampled low. Then drop ready, release the claim, and return to IDLE. This is a four-phase handshake.
- A consumer is claimed by at most one channel at a time. A claimed consumer is not re-arbitrated until its channel returns to IDLE.
- WRITE_ENABLE=0: write valid inputs are ignored, and mem_write_* and consumer_write_ready are tied to 0.

## Timing
- Reset (async, reset_n low): all channels go to IDLE and all claims clear. Every valid and ready output is 0; all address/data outputs are 0.
- All outputs are registered; there are no combinational input-to-output paths.
- Consumer valid sampled at edge N → mem_*_valid high after edge N.
- mem_*_ready sampled at edge M → consumer_*_ready and data high after edge M; mem_*_valid low after edge M.
- Consumer valid low sampled at edge K → ready low after edge K. The channel can claim again at edge K+1.
- Minimum round trip with a memory that asserts ready in the same cycle: consumer ready 2 cycles after valid.
- More requesters than channels: the excess requests wait with valid held. They are served lowest-index first as channels free up.
- mem_*_ready asserted while a channel is IDLE or RELAYING is ignored.
- reset_n asserted mid-transaction aborts it immediately. Memory must tolerate valid dropping before ready.

## Structure
- Package mem_pkg: channel_state_t enum (5 states, 3-bit encoding) and the claim-index width constant $clog2(NUM_CONSUMERS).
- Sub-module mem_channel: one per channel, holding the FSM, latched address/data, and consumer index.
- Top level: claim/arbitration logic, the claimed-consumer bitmask, and the output demux to consumers.

## Test plan
- Single read: consumer 0 reads address 0x10, memory returns 0xAB with ready in the same cycle → consumer_read_ready[0] rises 2 cycles after valid with data 0xAB, then clears 1 cycle after valid drops.
- Contention: 8 consumers read simultaneously, 4 channels → consumers 0–3 are served first, 4–7 after the channels free up, and every ready is matched to the correct address-derived data.
- Write: consumer 5 writes 0x3C to 0x22 → mem_write_valid carries 0x22/0x3C, and consumer_write_ready[5] rises after mem_write_ready.
- Slow memory: mem_read_ready delayed 10 cycles → mem_read_valid and address stay stable throughout, and the consumer sees no ready early.
- Reset mid-transaction: reset_n pulled low during READ_WAITING → all outputs are 0 immediately, and a fresh request after release completes normally.
- WRITE_ENABLE=0: consumer_write_valid asserted → mem_write_valid stays 0 and consumer_write_ready stays 0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for the memory responder and its channels.
package mem_pkg;

  typedef enum logic [2:0] {
    CH_IDLE           = 3'd0,
    CH_READ_WAITING   = 3'd1,
    CH_WRITE_WAITING  = 3'd2,
    CH_READ_RELAYING  = 3'd3,
    CH_WRITE_RELAYING = 3'd4
  } channel_state_t;

  localparam int unsigned NUM_CONSUMERS_DEFAULT = 8;

  // A single consumer still needs a 1-bit index field.
  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_BITS = idx_bits(NUM_CONSUMERS_DEFAULT);

endpackage

// File: rtl/mem_channel.sv
// One external memory port: claims a consumer, runs the memory handshake and
// relays the completion back with a four-phase handshake.
module mem_channel
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int IDX_W         = 3
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic                                    grant_i,
  input  logic                                    grant_read_i,
  input  logic [IDX_W-1:0]                        grant_idx_i,
  input  logic [NUM_CONSUMERS-1:0]                cons_read_valid_i,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] cons_read_address_i,
  input  logic [NUM_CONSUMERS-1:0]                cons_write_valid_i,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] cons_write_address_i,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] cons_write_data_i,
  input  logic                                    mem_read_ready_i,
  input  logic [DATA_BITS-1:0]                    mem_read_data_i,
  input  logic                                    mem_write_ready_i,
  output logic                                    idle_o,
  output logic                                    release_o,
  output logic [IDX_W-1:0]                        idx_o,
  output logic                                    mem_read_valid_o,
  output logic [ADDR_BITS-1:0]                    mem_read_address_o,
  output logic                                    mem_write_valid_o,
  output logic [ADDR_BITS-1:0]                    mem_write_address_o,
  output logic [DATA_BITS-1:0]                    mem_write_data_o,
  output logic                                    read_ready_o,
  output logic [DATA_BITS-1:0]                    read_data_o,
  output logic                                    write_ready_o
);

  channel_state_t         state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q;
  logic [DATA_BITS-1:0]   data_q;
  logic [IDX_W-1:0]       idx_q;

  // NOTE: async-reset flops are written only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CH_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CH_IDLE:
        if (grant_i) state_d = grant_read_i ? CH_READ_WAITING : CH_WRITE_WAITING;
      CH_READ_WAITING:
        if (mem_read_ready_i) state_d = CH_READ_RELAYING;
      CH_WRITE_WAITING:
        if (mem_write_ready_i) state_d = CH_WRITE_RELAYING;
      CH_READ_RELAYING:
        if (!cons_read_valid_i[idx_q]) state_d = CH_IDLE;
      CH_WRITE_RELAYING:
        if (!cons_write_valid_i[idx_q]) state_d = CH_IDLE;
      default:
        state_d = CH_IDLE;
    endcase
  end

  always_comb begin
    idle_o              = 1'b0;
    release_o           = 1'b0;
    mem_read_valid_o    = 1'b0;
    mem_read_address_o  = '0;
    mem_write_valid_o   = 1'b0;
    mem_write_address_o = '0;
    mem_write_data_o    = '0;
    read_ready_o        = 1'b0;
    read_data_o         = '0;
    write_ready_o       = 1'b0;
    unique case (state_q)
      CH_IDLE:
        idle_o = 1'b1;
      CH_READ_WAITING: begin
        mem_read_valid_o   = 1'b1;
        mem_read_address_o = addr_q;
      end
      CH_WRITE_WAITING: begin
        mem_write_valid_o   = 1'b1;
        mem_write_address_o = addr_q;
        mem_write_data_o    = data_q;
      end
      CH_READ_RELAYING: begin
        read_ready_o = 1'b1;
        read_data_o  = data_q;
        release_o    = !cons_read_valid_i[idx_q];
      end
      CH_WRITE_RELAYING: begin
        write_ready_o = 1'b1;
        release_o     = !cons_write_valid_i[idx_q];
      end
      default: idle_o = 1'b0;
    endcase
  end

  // One data register serves both directions: write data on claim, read data
  // on memory completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q <= '0;
      data_q <= '0;
      idx_q  <= '0;
    end else if (state_q == CH_IDLE && grant_i) begin
      idx_q  <= grant_idx_i;
      addr_q <= grant_read_i ? cons_read_address_i[grant_idx_i]
                             : cons_write_address_i[grant_idx_i];
      data_q <= cons_write_data_i[grant_idx_i];
    end else if (state_q == CH_READ_WAITING && mem_read_ready_i) begin
      data_q <= mem_read_data_i;
    end
  end

  assign idx_o = idx_q;

endmodule

// File: rtl/mem_responder.sv
// Arbitrates consumer read/write requests onto a set of memory channels and
// demultiplexes completions back to the owning consumer.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = 8,
  parameter int NUM_CHANNELS  = 4,
  parameter bit WRITE_ENABLE  = 1'b1
) (
  input  logic                                    clk,
  input  logic                                    reset_n,
  input  logic [NUM_CONSUMERS-1:0]                consumer_read_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address,
  output logic [NUM_CONSUMERS-1:0]                consumer_read_ready,
  output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data,
  input  logic [NUM_CONSUMERS-1:0]                consumer_write_valid,
  input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address,
  input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data,
  output logic [NUM_CONSUMERS-1:0]                consumer_write_ready,
  output logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  input  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  output logic [NUM_CHANNELS-1:0]                 mem_write_valid,
  output logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data,
  input  logic [NUM_CHANNELS-1:0]                 mem_write_ready
);

  localparam int IDX_W = int'(idx_bits(NUM_CONSUMERS));

  logic [NUM_CONSUMERS-1:0]               write_valid_eff;
  logic [NUM_CONSUMERS-1:0]               req;
  logic [NUM_CONSUMERS-1:0]               claimed_q, claimed_d;
  logic [NUM_CONSUMERS-1:0]               taken;
  logic [NUM_CHANNELS-1:0]                grant, grant_read;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0]     grant_idx;
  logic [NUM_CHANNELS-1:0]                ch_idle, ch_release;
  logic [NUM_CHANNELS-1:0][IDX_W-1:0]     ch_idx;
  logic [NUM_CHANNELS-1:0]                ch_rd_ready, ch_wr_ready;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_rd_data;
  logic [NUM_CHANNELS-1:0]                ch_wr_valid;
  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] ch_wr_addr;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] ch_wr_data;
  logic [NUM_CONSUMERS-1:0]               cons_wr_ready;

  // A read-only instance never sees a write request at all.
  assign write_valid_eff = WRITE_ENABLE ? consumer_write_valid : '0;
  assign req             = consumer_read_valid | write_valid_eff;

  // Channels are visited in ascending order; each consumer taken here is
  // hidden from higher channels in the same cycle.
  always_comb begin
    taken      = claimed_q;
    grant      = '0;
    grant_read = '0;
    grant_idx  = '0;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_idle[ch]) begin
        for (int c = 0; c < NUM_CONSUMERS; c++) begin
          if (!grant[ch] && req[c] && !taken[c]) begin
            grant[ch]      = 1'b1;
            grant_idx[ch]  = IDX_W'(c);
            grant_read[ch] = consumer_read_valid[c];
            taken[c]       = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    claimed_d = claimed_q;
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (ch_release[ch]) claimed_d[ch_idx[ch]] = 1'b0;
    end
    for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
      if (grant[ch]) claimed_d[grant_idx[ch]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      claimed_q <= '0;
    end else begin
      claimed_q <= claimed_d;
    end
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
    mem_channel #(
      .ADDR_BITS     (ADDR_BITS),
      .DATA_BITS     (DATA_BITS),
      .NUM_CONSUMERS (NUM_CONSUMERS),
      .IDX_W         (IDX_W)
    ) u_channel (
      .clk                  (clk),
      .reset_n              (reset_n),
      .grant_i              (grant[g]),
      .grant_read_i         (grant_read[g]),
      .grant_idx_i          (grant_idx[g]),
      .cons_read_valid_i    (consumer_read_valid),
      .cons_read_address_i  (consumer_read_address),
      .cons_write_valid_i   (write_valid_eff),
      .cons_write_address_i (consumer_write_address),
      .cons_write_data_i    (consumer_write_data),
      .mem_read_ready_i     (mem_read_ready[g]),
      .mem_read_data_i      (mem_read_data[g]),
      .mem_write_ready_i    (mem_write_ready[g]),
      .idle_o               (ch_idle[g]),
      .release_o            (ch_release[g]),
      .idx_o                (ch_idx[g]),
      .mem_read_valid_o     (mem_read_valid[g]),
      .mem_read_address_o   (mem_read_address[g]),
      .mem_write_valid_o    (ch_wr_valid[g]),
      .mem_write_address_o  (ch_wr_addr[g]),
      .mem_write_data_o     (ch_wr_data[g]),
      .read_ready_o         (ch_rd_ready[g]),
      .read_data_o          (ch_rd_data[g]),
      .write_ready_o        (ch_wr_ready[g])
    );
  end

  // At most one channel owns a consumer, so OR-merging the relays is exact.
  always_comb begin
    consumer_read_ready = '0;
    consumer_read_data  = '0;
    cons_wr_ready       = '0;
    for (int c = 0; c < NUM_CONSUMERS; c++) begin
      for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
        if (ch_idx[ch] == IDX_W'(c)) begin
          if (ch_rd_ready[ch]) begin
            consumer_read_ready[c] = 1'b1;
            consumer_read_data[c]  = consumer_read_data[c] | ch_rd_data[ch];
          end
          if (ch_wr_ready[ch]) cons_wr_ready[c] = 1'b1;
        end
      end
    end
  end

  assign consumer_write_ready = WRITE_ENABLE ? cons_wr_ready : '0;
  assign mem_write_valid      = WRITE_ENABLE ? ch_wr_valid   : '0;
  assign mem_write_address    = WRITE_ENABLE ? ch_wr_addr    : '0;
  assign mem_write_data       = WRITE_ENABLE ? ch_wr_data    : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: read/write handshakes, contention, slow
// memory, reset abort and a read-only instance.
module tb_mem_responder;

  localparam int NC = 8;
  localparam int NCH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Read-write instance signals
  logic [NC-1:0]         rv, wv, crr, cwr;
  logic [NC-1:0][7:0]    ra, wa, wd, crd;
  logic [NCH-1:0]        mrv, mrr, mwv, mwr;
  logic [NCH-1:0][7:0]   mra, mrd, mwa, mwd;

  // Read-only instance signals
  logic [NC-1:0]         ro_rv, ro_wv, ro_crr, ro_cwr;
  logic [NC-1:0][7:0]    ro_ra, ro_wa, ro_wd, ro_crd;
  logic [NCH-1:0]        ro_mrv, ro_mrr, ro_mwv, ro_mwr;
  logic [NCH-1:0][7:0]   ro_mra, ro_mrd, ro_mwa, ro_mwd;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rd_delay = 0;
  int wr_delay = 0;
  int rd_cnt [NCH];
  int wr_cnt [NCH];
  logic [7:0] wmem [256];

  mem_responder u_dut (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(rv), .consumer_read_address(ra),
    .consumer_read_ready(crr), .consumer_read_data(crd),
    .consumer_write_valid(wv), .consumer_write_address(wa),
    .consumer_write_data(wd), .consumer_write_ready(cwr),
    .mem_read_valid(mrv), .mem_read_address(mra),
    .mem_read_ready(mrr), .mem_read_data(mrd),
    .mem_write_valid(mwv), .mem_write_address(mwa),
    .mem_write_data(mwd), .mem_write_ready(mwr)
  );

  mem_responder #(.WRITE_ENABLE(1'b0)) u_ro (
    .clk(clk), .reset_n(reset_n),
    .consumer_read_valid(ro_rv), .consumer_read_address(ro_ra),
    .consumer_read_ready(ro_crr), .consumer_read_data(ro_crd),
    .consumer_write_valid(ro_wv), .consumer_write_address(ro_wa),
    .consumer_write_data(ro_wd), .consumer_write_ready(ro_cwr),
    .mem_read_valid(ro_mrv), .mem_read_address(ro_mra),
    .mem_read_ready(ro_mrr), .mem_read_data(ro_mrd),
    .mem_write_valid(ro_mwv), .mem_write_address(ro_mwa),
    .mem_write_data(ro_mwd), .mem_write_ready(ro_mwr)
  );

  // Memory model: data = address + 0x9B, ready after a configurable delay.
  always @(posedge clk) begin
    for (int ch = 0; ch < NCH; ch++) begin
      rd_cnt[ch] <= mrv[ch] ? rd_cnt[ch] + 1 : 0;
      wr_cnt[ch] <= mwv[ch] ? wr_cnt[ch] + 1 : 0;
      if (mwv[ch] && mwr[ch]) wmem[mwa[ch]] <= mwd[ch];
    end
  end

  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      mrr[ch]    = mrv[ch] && (rd_cnt[ch] >= rd_delay);
      mrd[ch]    = mra[ch] + 8'h9B;
      mwr[ch]    = mwv[ch] && (wr_cnt[ch] >= wr_delay);
      ro_mrr[ch] = ro_mrv[ch];
      ro_mrd[ch] = ro_mra[ch] + 8'h9B;
    end
  end
  assign ro_mwr = '1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int rdy_cyc [NC];
  int bad;
  logic [NC-1:0] pending;

  initial begin
    for (int ch = 0; ch < NCH; ch++) begin
      rd_cnt[ch] = 0;
      wr_cnt[ch] = 0;
    end
    reset_n = 1'b0;
    rv = '0; wv = '0; ra = '0; wa = '0; wd = '0;
    ro_rv = '0; ro_wv = '0; ro_ra = '0; ro_wa = '0; ro_wd = '0;
    repeat (2) step();
    check("rst_cons_ready", {crr, cwr}, 64'h0);
    check("rst_mem_valid", {mrv, mwv}, 64'h0);
    check("rst_mem_addr", {mra, mwa}, 64'h0);
    check("rst_cons_data", crd, 64'h0);
    reset_n = 1'b1;
    step();

    // Single read, memory answers in the same cycle
    rv[0] = 1'b1; ra[0] = 8'h10;
    step();
    check("rd_mem_valid", {mrv[0], mra[0]}, {1'b1, 8'h10});
    check("rd_no_early_ready", crr, 64'h0);
    step();
    check("rd_ready", crr, 64'h01);
    check("rd_data", crd[0], 64'hAB);
    check("rd_mem_valid_drop", mrv, 64'h0);
    rv[0] = 1'b0;
    step();
    check("rd_ready_clear", crr, 64'h0);

    // Contention: eight readers on four channels
    step();
    for (int c = 0; c < NC; c++) begin
      rv[c] = 1'b1;
      ra[c] = 8'(8'h50 + c * 8'h11);
      rdy_cyc[c] = -1;
    end
    pending = '1;
    cyc = 0;
    for (int t = 0; t < 40 && pending != '0; t++) begin
      step();
      for (int c = 0; c < NC; c++) begin
        if (pending[c] && crr[c]) begin
          check($sformatf("cont_data_%0d", c), crd[c], 64'(8'(8'h50 + c * 8'h11 + 8'h9B)));
          rdy_cyc[c] = cyc;
          rv[c] = 1'b0;
          pending[c] = 1'b0;
        end
      end
    end
    for (int c = 0; c < NC; c++)
      check($sformatf("cont_cycle_%0d", c), 64'(rdy_cyc[c]), (c < 4) ? 64'd2 : 64'd5);
    repeat (2) step();

    // Write from consumer 5
    wv[5] = 1'b1; wa[5] = 8'h22; wd[5] = 8'h3C;
    step();
    check("wr_mem_req", {mwv[0], mwa[0], mwd[0]}, {1'b1, 8'h22, 8'h3C});
    check("wr_no_early_ready", cwr, 64'h0);
    step();
    check("wr_ready", cwr, 64'h20);
    check("wr_mem_valid_drop", mwv, 64'h0);
    check("wr_mem_content", wmem[8'h22], 64'h3C);
    wv[5] = 1'b0;
    step();
    check("wr_ready_clear", cwr, 64'h0);

    // Read wins over write on the same consumer
    rv[6] = 1'b1; ra[6] = 8'h07; wv[6] = 1'b1; wa[6] = 8'h08; wd[6] = 8'h99;
    step();
    check("prio_read_first", {mrv[0], mwv[0], mra[0]}, {2'b10, 8'h07});
    step();
    check("prio_read_done", {crr[6], crd[6]}, {1'b1, 8'hA2});
    rv[6] = 1'b0;
    repeat (2) step();
    check("prio_write_next", {mwv[0], mwa[0], mwd[0]}, {1'b1, 8'h08, 8'h99});
    step();
    check("prio_write_done", cwr, 64'h40);
    wv[6] = 1'b0;
    repeat (2) step();

    // Slow memory: ready ten cycles late
    rd_delay = 10;
    rv[2] = 1'b1; ra[2] = 8'h40;
    bad = 0;
    for (int i = 1; i <= 11; i++) begin
      step();
      if (!(mrv[0] === 1'b1 && mra[0] === 8'h40 && crr === 8'h00)) bad++;
    end
    check("slow_stable", 64'(bad), 64'd0);
    step();
    check("slow_ready", {crr, crd[2]}, {8'h04, 8'hDB});
    rv[2] = 1'b0;
    step();
    rd_delay = 0;
    step();

    // Reset while a read is waiting on memory
    rd_delay = 10;
    rv[1] = 1'b1; ra[1] = 8'h30;
    repeat (3) step();
    check("rstmid_waiting", {mrv, mra[0]}, {4'h1, 8'h30});
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", {mrv, mwv, crr, cwr}, 64'h0);
    check("rstmid_addr", {mra, mwa}, 64'h0);
    rv[1] = 1'b0;
    step();
    reset_n = 1'b1;
    rd_delay = 0;
    step();
    rv[1] = 1'b1;
    step();
    check("rstmid_req_again", {mrv[0], mra[0]}, {1'b1, 8'h30});
    step();
    check("rstmid_complete", {crr, crd[1]}, {8'h02, 8'hCB});
    rv[1] = 1'b0;
    step();
    check("rstmid_clear", crr, 64'h0);

    // Read-only instance: writes ignored, reads still served
    ro_wv[3] = 1'b1; ro_wa[3] = 8'h44; ro_wd[3] = 8'h55;
    ro_rv[4] = 1'b1; ro_ra[4] = 8'h12;
    bad = 0;
    step();
    if (ro_mwv !== '0 || ro_cwr !== '0 || ro_mwa !== '0) bad++;
    step();
    check("ro_read_ready", {ro_crr, ro_crd[4]}, {8'h10, 8'hAD});
    ro_rv[4] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (ro_mwv !== '0 || ro_cwr !== '0 || ro_mwa !== '0) bad++;
    end
    check("ro_write_ignored", 64'(bad), 64'd0);
    ro_wv[3] = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
